// File: rtl/uart_receiver.sv
// UART receive path: 2-FF synchroniser, mid-bit sampling FSM, odd-parity and
// stop-bit check, and a valid/ready holding register with overrun reporting.
module uart_receiver #(
  parameter int CLK_KHZ     = 100000,
  parameter int BODS        = 9600,
  parameter int DATA_AMOUNT = 8
) (
  input  logic                   clk_i,
  input  logic                   arst_i,
  input  logic                   rx_i,
  input  logic                   ready_i,
  output logic [DATA_AMOUNT-1:0] data_o,
  output logic                   valid_o,
  output logic                   parity_err_o,
  output logic                   frame_err_o,
  output logic                   overrun_o,
  output logic                   busy_o
);

  localparam int PERIOD = CLK_KHZ * 1000 / BODS;
  localparam int HALF   = PERIOD / 2;
  localparam int BCW    = (PERIOD > 2) ? $clog2(PERIOD) : 1;
  localparam int DCW    = (DATA_AMOUNT > 1) ? $clog2(DATA_AMOUNT) : 1;

  localparam logic [BCW-1:0] BAUD_MID  = BCW'(HALF - 1);
  localparam logic [BCW-1:0] BAUD_LAST = BCW'(PERIOD - 1);
  localparam logic [DCW-1:0] BIT_LAST  = DCW'(DATA_AMOUNT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t                 state;
  logic [1:0]             sync_q;
  logic                   rx_s;
  logic                   armed;
  logic [BCW-1:0]         baud_cnt;
  logic [DCW-1:0]         bit_cnt;
  logic [DATA_AMOUNT-1:0] shift_q;
  logic [DATA_AMOUNT:0]   shift_in;
  logic                   par_bit;

  // Synchroniser resets to the idle line level so reset never looks like a start.
  always_ff @(posedge clk_i) begin
    if (arst_i) sync_q <= 2'b11;
    else        sync_q <= {sync_q[0], rx_i};
  end

  assign rx_s     = sync_q[1];
  assign shift_in = {rx_s, shift_q};
  assign busy_o   = (state != S_IDLE);

  always_ff @(posedge clk_i) begin
    if (arst_i) begin
      state        <= S_IDLE;
      armed        <= 1'b0;
      baud_cnt     <= '0;
      bit_cnt      <= '0;
      shift_q      <= '0;
      par_bit      <= 1'b0;
      data_o       <= '0;
      valid_o      <= 1'b0;
      parity_err_o <= 1'b0;
      frame_err_o  <= 1'b0;
      overrun_o    <= 1'b0;
    end else begin
      overrun_o <= 1'b0;
      if (valid_o && ready_i) valid_o <= 1'b0;

      case (state)
        S_IDLE: begin
          baud_cnt <= '0;
          bit_cnt  <= '0;
          // Arming needs the line seen high, so a held break cannot restart.
          if (rx_s) begin
            armed <= 1'b1;
          end else if (armed) begin
            armed <= 1'b0;
            state <= S_START;
          end
        end

        S_START: begin
          if (baud_cnt == BAUD_MID) begin
            baud_cnt <= '0;
            state    <= rx_s ? S_IDLE : S_DATA;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end

        S_DATA: begin
          if (baud_cnt == BAUD_LAST) begin
            baud_cnt <= '0;
            shift_q  <= shift_in[DATA_AMOUNT:1];
            if (bit_cnt == BIT_LAST) state <= S_PARITY;
            else                     bit_cnt <= bit_cnt + 1'b1;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end

        S_PARITY: begin
          if (baud_cnt == BAUD_LAST) begin
            baud_cnt <= '0;
            par_bit  <= rx_s;
            state    <= S_STOP;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end

        S_STOP: begin
          if (baud_cnt == BAUD_LAST) begin
            // Leave at mid stop bit so a following start edge is not missed.
            baud_cnt     <= '0;
            state        <= S_IDLE;
            data_o       <= shift_q;
            parity_err_o <= ~(^shift_q ^ par_bit);
            frame_err_o  <= ~rx_s;
            valid_o      <= 1'b1;
            overrun_o    <= valid_o && !ready_i;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_receiver.sv
// Bench for uart_receiver: frame-level reference model feeding a scoreboard,
// with a monitor that pops on every frame load seen at the outputs.
module tb_uart_receiver;
  localparam int CLK_KHZ = 1000;
  localparam int BODS    = 100000;
  localparam int DA      = 8;
  localparam int PER     = 10;

  logic          clk = 1'b0;
  logic          arst_i, rx_i, ready_i;
  logic [DA-1:0] data_o;
  logic          valid_o, parity_err_o, frame_err_o, overrun_o, busy_o;

  typedef struct packed {
    logic [7:0] d;
    logic       pe;
    logic       fe;
    logic       ov;
  } exp_t;

  exp_t sb[$];
  int   nvec = 0, nerr = 0;
  int   cyc = 0, rmode = 0, ready_at = -1;
  int   lat, kk;
  logic seen;

  uart_receiver #(.CLK_KHZ(CLK_KHZ), .BODS(BODS), .DATA_AMOUNT(DA)) dut (
    .clk_i(clk), .arst_i(arst_i), .rx_i(rx_i), .ready_i(ready_i),
    .data_o(data_o), .valid_o(valid_o), .parity_err_o(parity_err_o),
    .frame_err_o(frame_err_o), .overrun_o(overrun_o), .busy_o(busy_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  // Odd parity: good when data ones plus the parity bit is an odd count.
  function automatic exp_t model(input logic [7:0] d, input logic par, input logic stp,
                                 input logic ov);
    exp_t e;
    e.d  = d;
    e.pe = ((($countones(d) + int'(par)) % 2) == 0);
    e.fe = !stp;
    e.ov = ov;
    return e;
  endfunction

  // Called at a negedge; drives 11 bits of PER cycles, optionally aborting with reset.
  task automatic send_frame(input logic [7:0] d, input logic par, input logic stp,
                            input int abort_at);
    logic [10:0] fr;
    fr = {stp, par, d, 1'b0};
    for (int j = 0; j < 11 * PER; j++) begin
      if (abort_at > 0 && j == abort_at) begin
        arst_i = 1'b1;
        rx_i   = 1'b1;
        @(negedge clk);
        arst_i = 1'b0;
        return;
      end
      rx_i = fr[j / PER];
      @(negedge clk);
    end
    rx_i = 1'b1;
  endtask

  task automatic monitor();
    logic last_v, xfer, load;
    exp_t e;
    last_v = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      xfer = last_v && ready_i;
      load = valid_o && (!last_v || xfer || overrun_o);
      if (load) begin
        if (sb.size() == 0) begin
          nvec++;
          nerr++;
          $display("FAIL unexpected_frame: got data 0x%0h, want no frame", data_o);
        end else begin
          e = sb.pop_front();
          chk("frame_data", 32'(data_o), 32'(e.d));
          chk("frame_parity_err", 32'(parity_err_o), 32'(e.pe));
          chk("frame_frame_err", 32'(frame_err_o), 32'(e.fe));
          chk("frame_overrun", 32'(overrun_o), 32'(e.ov));
        end
      end
      last_v = valid_o;
    end
  endtask

  // 0: ready low, 1: one-cycle pulse per held word, 2: tied high, 3: high on cycle ready_at
  task automatic ready_drv();
    forever begin
      @(negedge clk);
      case (rmode)
        0:       ready_i = 1'b0;
        1:       ready_i = valid_o && !ready_i;
        2:       ready_i = 1'b1;
        default: ready_i = (cyc == ready_at);
      endcase
    end
  endtask

  initial begin
    logic [7:0] d;
    logic       par, stp;
    arst_i  = 1'b1;
    rx_i    = 1'b1;
    ready_i = 1'b0;
    fork
      monitor();
      ready_drv();
      begin
        #500000;
        $display("FAIL timeout: got no end of test, want completion");
        $fatal(1);
      end
    join_none

    repeat (3) @(negedge clk);
    chk("rst_data", 32'(data_o), 0);
    chk("rst_valid", 32'(valid_o), 0);
    chk("rst_parity_err", 32'(parity_err_o), 0);
    chk("rst_frame_err", 32'(frame_err_o), 0);
    chk("rst_overrun", 32'(overrun_o), 0);
    chk("rst_busy", 32'(busy_o), 0);
    arst_i = 1'b0;
    repeat (5) @(negedge clk);

    // Good frame and latency
    rmode = 0;
    sb.push_back(model(8'hA5, 1'b1, 1'b1, 1'b0));
    kk = cyc + 1;
    lat = -1;
    fork
      send_frame(8'hA5, 1'b1, 1'b1, 0);
      begin
        for (int i = 0; i < 200; i++) begin
          @(negedge clk);
          if (valid_o) begin
            lat = cyc - kk;
            break;
          end
        end
      end
    join
    chk("latency", 32'(lat), 107);
    chk("good_data", 32'(data_o), 32'h A5);
    chk("good_parity_err", 32'(parity_err_o), 0);
    chk("good_frame_err", 32'(frame_err_o), 0);
    rmode = 1;
    repeat (5) @(negedge clk);
    chk("good_drained", 32'(valid_o), 0);

    // Back-to-back with pulsed ready
    sb.push_back(model(8'h00, 1'b1, 1'b1, 1'b0));
    sb.push_back(model(8'hFF, 1'b1, 1'b1, 1'b0));
    send_frame(8'h00, 1'b1, 1'b1, 0);
    send_frame(8'hFF, 1'b1, 1'b1, 0);
    repeat (5) @(negedge clk);

    // Parity error, then stop-bit error
    sb.push_back(model(8'h01, 1'b1, 1'b1, 1'b0));
    send_frame(8'h01, 1'b1, 1'b1, 0);
    sb.push_back(model(8'h3C, 1'b1, 1'b0, 1'b0));
    send_frame(8'h3C, 1'b1, 1'b0, 0);
    repeat (5) @(negedge clk);

    // Glitch: 3-cycle low is a false start
    rx_i = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (i == 2) rx_i = 1'b1;
      if (busy_o) seen = 1'b1;
    end
    chk("glitch_busy_rise", 32'(seen), 1);
    repeat (10) @(negedge clk);
    chk("glitch_idle", 32'(busy_o), 0);
    chk("glitch_no_valid", 32'(valid_o), 0);

    // Break: one all-zero frame, then no restart while low
    sb.push_back(model(8'h00, 1'b0, 1'b0, 1'b0));
    rx_i = 1'b0;
    repeat (200) @(negedge clk);
    chk("break_no_restart", 32'(busy_o), 0);
    rx_i = 1'b1;
    repeat (20) @(negedge clk);
    chk("break_idle", 32'(busy_o), 0);

    // Overrun with ready low
    rmode = 0;
    sb.push_back(model(8'h11, 1'b0, 1'b1, 1'b0));
    sb.push_back(model(8'h22, 1'b1, 1'b1, 1'b1));
    send_frame(8'h11, 1'b0, 1'b1, 0);
    send_frame(8'h22, 1'b1, 1'b1, 0);
    chk("ovr_pulse_ended", 32'(overrun_o), 0);
    chk("ovr_valid_held", 32'(valid_o), 1);
    chk("ovr_data", 32'(data_o), 32'h22);

    // Ready high on the load cycle: transfer plus load, no overrun
    sb.push_back(model(8'h44, 1'b1, 1'b1, 1'b0));
    ready_at = cyc + 1 + 106;
    rmode = 3;
    send_frame(8'h44, 1'b1, 1'b1, 0);
    chk("ready_load_valid", 32'(valid_o), 1);
    chk("ready_load_data", 32'(data_o), 32'h44);
    rmode = 1;
    repeat (5) @(negedge clk);
    chk("ready_load_drained", 32'(valid_o), 0);

    // Reset mid-frame discards the held word and the partial frame
    rmode = 0;
    sb.push_back(model(8'h66, 1'b1, 1'b1, 1'b0));
    send_frame(8'h66, 1'b1, 1'b1, 0);
    send_frame(8'h77, 1'b1, 1'b1, 50);
    chk("mid_rst_data", 32'(data_o), 0);
    chk("mid_rst_valid", 32'(valid_o), 0);
    chk("mid_rst_parity_err", 32'(parity_err_o), 0);
    chk("mid_rst_frame_err", 32'(frame_err_o), 0);
    chk("mid_rst_overrun", 32'(overrun_o), 0);
    chk("mid_rst_busy", 32'(busy_o), 0);
    repeat (5) @(negedge clk);
    rmode = 1;
    sb.push_back(model(8'h5A, 1'b1, 1'b1, 1'b0));
    send_frame(8'h5A, 1'b1, 1'b1, 0);
    repeat (5) @(negedge clk);

    // Random frames, ready tied high
    rmode = 2;
    for (int n = 0; n < 12; n++) begin
      d   = 8'($urandom);
      par = 1'($urandom_range(0, 1));
      stp = ($urandom_range(0, 3) != 0);
      sb.push_back(model(d, par, stp, 1'b0));
      send_frame(d, par, stp, 0);
      repeat ($urandom_range(3, 15)) @(negedge clk);
    end

    for (int i = 0; i < 300; i++) begin
      if (sb.size() == 0) break;
      @(negedge clk);
    end
    chk("scoreboard_empty", 32'(sb.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/uart_receiver.md
# uart_receiver

Serial-to-parallel UART receiver, the receive side of the team's UART link. Frame format on the line: start bit (0), DATA_AMOUNT data bits LSB first, odd-parity bit, stop bit (1). The block synchronises `rx_i`, detects the start edge, samples each bit at mid-bit, checks parity and stop bit, and presents the word on a valid/ready holding register to the downstream logic.

## Interface
- `CLK_KHZ`, 100000, system clock frequency in kHz
- `BODS`, 9600, line baud rate
- `DATA_AMOUNT`, 8, data bits per frame
- `clk_i`  in  1  system clock; all logic on its rising edge
- `arst_i`  in  1  reset; synchronous, active-high
- `rx_i`  in  1  serial line, asynchronous to `clk_i`, idles high
- `ready_i`  in  1  downstream accepts the held word
- `data_o`  out  DATA_AMOUNT  received word
- `valid_o`  out  1  `data_o` and the error flags hold an unconsumed frame
- `parity_err_o`  out  1  parity check failed for the held frame
- `frame_err_o`  out  1  stop bit sampled 0 for the held frame
- `overrun_o`  out  1  one-cycle pulse: unconsumed frame overwritten
- `busy_o`  out  1  FSM not in IDLE

## Operation
- PERIOD = CLK_KHZ*1000/BODS (integer divide); HALF = PERIOD/2. Bit counter width is $clog2(DATA_AMOUNT), baud counter width is $clog2(PERIOD).
- `rx_i` passes through a 2-FF synchroniser; both FFs reset to 1. The FSM uses only the second FF output, `rx_s`.
- `armed` flag: set while `rx_s`=1 in IDLE, cleared on leaving IDLE and on reset. A start is accepted only when armed, so a line held low (break) never re-triggers.
- FSM states and transitions:
  - IDLE: if `armed` and `rx_s`=0, go to START with baud counter 0.
  - START: sample at counter == HALF-1. If `rx_s`=0, go to DATA; if 1, it is a false start and the FSM returns to IDLE with no output.
  - DATA: sample at counter == PERIOD-1 and shift into the shift register LSB-first. After the DATA_AMOUNT-th sample, go to PARITY.
  - PARITY: sample at PERIOD-1, then go to STOP.
  - STOP: sample at PERIOD-1, then go to IDLE immediately (half a bit early, so back-to-back frames are tolerated).
  - The baud counter clears on every sample and while in IDLE.
- Parity: the frame is good when the XOR of the data bits and the parity bit equals 1 (odd). `parity_err_o` = that XOR == 0.
- Stop sample: on the same edge it loads `data_o`, `parity_err_o` and `frame_err_o` (= ~stop sample) and sets `valid_o`=1. Frames with errors are still delivered.
- Handshake: a transfer occurs on a cycle with `valid_o`&&`ready_i`. After a transfer, `valid_o` drops the next cycle unless a new frame loads on that same edge.
- Overrun: a new frame loads while `valid_o`=1 and `ready_i`=0. Result: new data overwrites the held frame, `valid_o` stays 1, and `overrun_o` pulses for 1 cycle. If `ready_i`=1 on the load cycle, there is no overrun.

## Timing
- Reset values: `data_o`=0, `valid_o`=0, `parity_err_o`=0, `frame_err_o`=0, `overrun_o`=0, `busy_o`=0; FSM in IDLE; counters 0; `armed`=0.
- Reset asserted mid-frame aborts the frame: no partial word is delivered, and a held word is discarded.
- Latency: let edge k be the first edge sampling `rx_i`=0, with the receiver armed. `valid_o` is 1 after edge k+2+HALF+(DATA_AMOUNT+2)*PERIOD.
- `busy_o` is 1 from edge k+2 until the edge of the stop sample.
- Data bit i is sampled at edge k+2+HALF+(i+1)*PERIOD, i=0..DATA_AMOUNT-1.
- `valid_o` falls on the edge after the accepting cycle. Maximum rate: `ready_i` tied 1 gives a `valid_o` pulse of exactly 1 cycle per frame.

## Test plan
Bench parameters: CLK_KHZ=1000, BODS=100000, so PERIOD=10 and HALF=5.
- **Good frame:** send 0xA5 with parity 1 and stop bit 1, `ready_i`=0. Required: `valid_o` rises exactly 107 cycles after rx falls, `data_o`=0xA5, both error flags 0.
- **Back-to-back with early ready:** send 0x00 (parity 1) then 0xFF (parity 1) back-to-back, with `ready_i` pulsed 1 cycle after each valid. Required: both words are received in order, no `overrun_o`.
- **Parity error:** send 0x01 with parity bit 1. Required: `valid_o`=1, `data_o`=0x01, `parity_err_o`=1. **Stop-bit error:** send 0x3C with stop bit 0. Required: `frame_err_o`=1.
- **Glitch and break:** drive a 3-cycle low glitch on rx. Required: `busy_o` rises, then returns to IDLE with no `valid_o`. Then hold rx low for 200 cycles. Required: exactly one frame is delivered (`data_o`=0x00, `frame_err_o`=1) and there is no second start until rx returns high.
- **Overrun:** send 0x11 then 0x22 with `ready_i`=0. Required: `overrun_o` pulses for 1 cycle when 0x22 loads, `data_o`=0x22, `valid_o` stays 1. Repeat with `ready_i`=1 on the load cycle. Required: no overrun.
- **Reset mid-frame:** assert `arst_i` for 1 cycle at cycle 50 of a frame. Required: all outputs 0 the next cycle and no word delivered. The next full frame 0x5A is received correctly.
